// File: rtl/flow_am_scheduler.sv
// flow_am_scheduler: admits encoder blocks, opens periodic alignment-marker
// slot groups and tags every output with a balanced 2-flow select.
module flow_am_scheduler #(
    parameter int unsigned BITS_BLOCK        = 257,
    parameter int unsigned MAX_BLOCKS_AM     = 40,
    parameter int unsigned BLOCKS_REPETITION = 8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic [BITS_BLOCK-1:0] i_block,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [BITS_BLOCK-1:0] o_block,
    output logic                  o_am_slot,
    output logic                  o_am_start,
    output logic                  o_flow_sel
);

    localparam int unsigned AW = $clog2(MAX_BLOCKS_AM);
    localparam int unsigned DW = $clog2(BLOCKS_REPETITION);

    // Odd counts would break the flow-0 alignment of every AM group.
    if ((MAX_BLOCKS_AM < 2) || ((MAX_BLOCKS_AM % 2) != 0)) begin : g_bad_am
        $error("flow_am_scheduler: MAX_BLOCKS_AM must be even and >= 2");
    end
    if ((BLOCKS_REPETITION < 2) || ((BLOCKS_REPETITION % 2) != 0)) begin : g_bad_rep
        $error("flow_am_scheduler: BLOCKS_REPETITION must be even and >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AM   = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         am_cnt_q, am_cnt_d;
    logic [DW-1:0]         data_cnt_q, data_cnt_d;
    logic                  flow_q, flow_d;
    logic                  valid_q, valid_d;
    logic [BITS_BLOCK-1:0] block_q, block_d;
    logic                  am_slot_q, am_slot_d;
    logic                  am_start_q, am_start_d;
    logic                  flow_sel_q, flow_sel_d;

    // Ready is a pure state decode so upstream never sees a combinational loop.
    assign o_ready = (state_q == ST_DATA);

    // Next-state, counter and output-register decode.
    always_comb begin
        state_d    = state_q;
        am_cnt_d   = am_cnt_q;
        data_cnt_d = data_cnt_q;
        flow_d     = flow_q;
        valid_d    = 1'b0;
        block_d    = '0;
        am_slot_d  = 1'b0;
        am_start_d = 1'b0;
        flow_sel_d = flow_sel_q;

        unique case (state_q)
            ST_IDLE: begin
                flow_d     = 1'b0;
                flow_sel_d = 1'b0;
                if (i_enable) begin
                    state_d = ST_AM;
                end
            end
            ST_AM: begin
                valid_d    = 1'b1;
                am_slot_d  = 1'b1;
                am_start_d = (am_cnt_q == '0);
                flow_sel_d = flow_q;
                flow_d     = ~flow_q;
                if (am_cnt_q == AW'(MAX_BLOCKS_AM - 1)) begin
                    am_cnt_d = '0;
                    state_d  = ST_DATA;
                end else begin
                    am_cnt_d = am_cnt_q + AW'(1);
                end
            end
            ST_DATA: begin
                if (i_valid) begin
                    valid_d    = 1'b1;
                    block_d    = i_block;
                    flow_sel_d = flow_q;
                    flow_d     = ~flow_q;
                    if (data_cnt_q == DW'(BLOCKS_REPETITION - 1)) begin
                        data_cnt_d = '0;
                        state_d    = i_enable ? ST_AM : ST_IDLE;
                    end else begin
                        data_cnt_d = data_cnt_q + DW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; async reset drops any in-flight block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            am_cnt_q   <= '0;
            data_cnt_q <= '0;
            flow_q     <= 1'b0;
            valid_q    <= 1'b0;
            block_q    <= '0;
            am_slot_q  <= 1'b0;
            am_start_q <= 1'b0;
            flow_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            am_cnt_q   <= am_cnt_d;
            data_cnt_q <= data_cnt_d;
            flow_q     <= flow_d;
            valid_q    <= valid_d;
            block_q    <= block_d;
            am_slot_q  <= am_slot_d;
            am_start_q <= am_start_d;
            flow_sel_q <= flow_sel_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_block    = block_q;
    assign o_am_slot  = am_slot_q;
    assign o_am_start = am_start_q;
    assign o_flow_sel = flow_sel_q;

endmodule
